// File: rtl/y86_pkg.sv
// Shared Y86-64 control definitions: icodes, status codes, FSM states and
// instruction-class helpers used by the sequential controller.
package y86_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned STAT_W  = 3;

    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    typedef enum logic [STAT_W-1:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXEC      = 4'd3,
        S_MEM       = 4'd4,
        S_WB        = 4'd5,
        S_PCUPD     = 4'd6,
        S_HALT      = 4'd7,
        S_ERR       = 4'd8,
        S_STEP_WAIT = 4'd9
    } state_e;

    // One strobe per datapath stage, registered as a group.
    typedef struct packed {
        logic fetch_en;
        logic decode_en;
        logic exec_en;
        logic cc_load;
        logic dmem_rd;
        logic dmem_wr;
        logic wb_en;
        logic pc_load;
    } stage_en_t;

    function automatic logic needs_mem(input logic [ICODE_W-1:0] ic);
        return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
    endfunction

    function automatic logic is_mem_write(input logic [ICODE_W-1:0] ic);
        return ic inside {I_RMMOVQ, I_CALL, I_PUSHQ};
    endfunction

    function automatic logic writes_rf(input logic [ICODE_W-1:0] ic);
        return ic inside {I_RRMOVQ, I_IRMOVQ, I_MRMOVQ, I_OPQ,
                          I_CALL, I_RET, I_PUSHQ, I_POPQ};
    endfunction

endpackage

// File: rtl/y86_seq_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side,
// slave = datapath/memory side.
interface y86_seq_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic                          start;
    logic [y86_pkg::ICODE_W-1:0]   icode;
    logic                          valid_instruction;
    logic                          valid_memory;
    logic                          mem_ready;
    logic                          dmem_error;

    logic                          fetch_en;
    logic                          decode_en;
    logic                          exec_en;
    logic                          cc_load;
    logic                          dmem_rd;
    logic                          dmem_wr;
    logic                          wb_en;
    logic                          pc_load;
    logic [y86_pkg::STAT_W-1:0]    stat;
    logic                          busy;
    logic [CNT_W-1:0]              retired_cnt;

    modport master (
        input  start, icode, valid_instruction, valid_memory, mem_ready, dmem_error,
        output fetch_en, decode_en, exec_en, cc_load, dmem_rd, dmem_wr, wb_en,
               pc_load, stat, busy, retired_cnt
    );

    modport slave (
        output start, icode, valid_instruction, valid_memory, mem_ready, dmem_error,
        input  fetch_en, decode_en, exec_en, cc_load, dmem_rd, dmem_wr, wb_en,
               pc_load, stat, busy, retired_cnt
    );
endinterface

// File: rtl/y86_mem_wait_timer.sv
// Counts MEMORY-state cycles spent waiting for mem_ready; flags the cycle on
// which the count would reach MEM_TIMEOUT.
module y86_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_c
);
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign expire_c = inc_i && !clr_i && (cnt_d == CW'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle control FSM for the sequential Y86-64 datapath with a
// variable-latency data-memory handshake, status reporting and a retire
// counter. Optional single-step mode: define Y86_SINGLE_STEP_EN.
module y86_seq_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef Y86_SINGLE_STEP_EN
    input  logic            step,
`endif
    y86_seq_ctrl_if.master  bus
);

    state_e               state_q,   state_d;
    logic [ICODE_W-1:0]   icode_q,   icode_d;
    stat_e                stat_q,    stat_d;
    logic [CNT_W-1:0]     retired_q, retired_d;
    logic [CNT_W-1:0]     retired_sat;
    stage_en_t            en_q,      en_d;
    logic                 busy_q,    busy_d;

    logic                 tmr_clr;
    logic                 tmr_inc;
    logic                 tmr_expire;

    assign tmr_clr = (state_q != S_MEM);
    assign tmr_inc = (state_q == S_MEM) && !bus.mem_ready;

    y86_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmr_clr),
        .inc_i    (tmr_inc),
        .expire_c (tmr_expire)
    );

    assign retired_sat = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);

    // State register plus registered Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            icode_q   <= '0;
            stat_q    <= STAT_AOK;
            retired_q <= '0;
            en_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            icode_q   <= icode_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, latched icode, status and retire count.
    always_comb begin
        state_d   = state_q;
        icode_d   = icode_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                icode_d = bus.icode;
                if (!bus.valid_memory) begin
                    state_d = S_ERR;
                    stat_d  = STAT_ADR;
                end else if (!bus.valid_instruction) begin
                    state_d = S_ERR;
                    stat_d  = STAT_INS;
                end else if (bus.icode == I_HALT) begin
                    state_d   = S_HALT;
                    stat_d    = STAT_HLT;
                    retired_d = retired_sat;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = needs_mem(icode_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (bus.dmem_error) begin
                        state_d = S_ERR;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmr_expire) begin
                    state_d = S_ERR;
                    stat_d  = STAT_ADR;
                end
            end
            // Retire is counted on PCUPD entry so it lines up with pc_load.
            S_WB: begin
                state_d   = S_PCUPD;
                retired_d = retired_sat;
            end
`ifdef Y86_SINGLE_STEP_EN
            S_PCUPD:     state_d = S_STEP_WAIT;
            S_STEP_WAIT: begin
                if (step) begin
                    state_d = S_FETCH;
                end
            end
`else
            S_PCUPD:     state_d = S_FETCH;
`endif
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Stage strobes decoded from the upcoming state so they register in step.
    always_comb begin
        en_d   = '0;
        busy_d = 1'b0;
        case (state_d)
            S_FETCH: begin
                en_d.fetch_en = 1'b1;
                busy_d        = 1'b1;
            end
            S_DECODE: begin
                en_d.decode_en = 1'b1;
                busy_d         = 1'b1;
            end
            S_EXEC: begin
                en_d.exec_en = 1'b1;
                en_d.cc_load = (icode_q == I_OPQ);
                busy_d       = 1'b1;
            end
            S_MEM: begin
                en_d.dmem_rd = needs_mem(icode_q) && !is_mem_write(icode_q);
                en_d.dmem_wr = is_mem_write(icode_q);
                busy_d       = 1'b1;
            end
            S_WB: begin
                en_d.wb_en = writes_rf(icode_q);
                busy_d     = 1'b1;
            end
            S_PCUPD: begin
                en_d.pc_load = 1'b1;
                busy_d       = 1'b1;
            end
            S_STEP_WAIT: busy_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.fetch_en    = en_q.fetch_en;
    assign bus.decode_en   = en_q.decode_en;
    assign bus.exec_en     = en_q.exec_en;
    assign bus.cc_load     = en_q.cc_load;
    assign bus.dmem_rd     = en_q.dmem_rd;
    assign bus.dmem_wr     = en_q.dmem_wr;
    assign bus.wb_en       = en_q.wb_en;
    assign bus.pc_load     = en_q.pc_load;
    assign bus.stat        = stat_q;
    assign bus.busy        = busy_q;
    assign bus.retired_cnt = retired_q;

endmodule
